// File: rtl/fetch_stall_ctrl.sv
// fetch_stall_ctrl: front-end controller owning the PC and the IF/ID register.
// It holds both on a load-use stall, squashes IF/ID on a taken EX branch and
// keeps saturating stall/flush counters for performance debug.
// Per-cycle event priority: flush > stall > advance.
//
// Ports:
//   clk, rst          - clock (rising edge), asynchronous active-high reset
//   stall             - load-use stall request from hazard detection
//   branch_taken_ex   - taken branch/jump resolved in EX
//   branch_target_ex  - redirect address, valid with branch_taken_ex
//   imem_rdata        - instruction at imem_addr (combinational read)
//   imem_addr         - current PC
//   if_id_pc/instr/valid - IF/ID pipeline register contents
//   id_ex_bubble      - combinational; ID/EX loads a NOP when high
//   stall_cycles      - saturating count of effective stall cycles
//   flush_count       - saturating count of taken-branch flushes
module fetch_stall_ctrl #(
  parameter int unsigned            XLEN     = 32,
  parameter logic [XLEN-1:0]        RESET_PC = '0,
  parameter int unsigned            CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             branch_taken_ex,
  input  logic [XLEN-1:0]  branch_target_ex,
  input  logic [XLEN-1:0]  imem_rdata,
  output logic [XLEN-1:0]  imem_addr,
  output logic [XLEN-1:0]  if_id_pc,
  output logic [XLEN-1:0]  if_id_instr,
  output logic             if_id_valid,
  output logic             id_ex_bubble,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  // addi x0,x0,0 - canonical NOP placed in a squashed IF/ID slot
  localparam logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013);
  localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  if_id_pc_q, if_id_pc_d;
  logic [XLEN-1:0]  if_id_instr_q, if_id_instr_d;
  logic             if_id_valid_q, if_id_valid_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  // Next-state selection: flush beats stall beats advance
  always_comb begin
    pc_d           = pc_q;
    if_id_pc_d     = if_id_pc_q;
    if_id_instr_d  = if_id_instr_q;
    if_id_valid_d  = if_id_valid_q;
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;

    if (branch_taken_ex) begin
      // A simultaneous stall belongs to a squashed consumer and is dropped
      pc_d          = branch_target_ex;
      if_id_instr_d = NOP_INSTR;
      if_id_valid_d = 1'b0;
      if (flush_count_q != CNT_MAX) flush_count_d = flush_count_q + CNT_ONE;
    end else if (stall) begin
      if (stall_cycles_q != CNT_MAX) stall_cycles_d = stall_cycles_q + CNT_ONE;
    end else begin
      pc_d          = pc_q + PC_STEP;
      if_id_pc_d    = pc_q;
      if_id_instr_d = imem_rdata;
      if_id_valid_d = 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q           <= RESET_PC;
      if_id_pc_q     <= '0;
      if_id_instr_q  <= NOP_INSTR;
      if_id_valid_q  <= 1'b0;
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      pc_q           <= pc_d;
      if_id_pc_q     <= if_id_pc_d;
      if_id_instr_q  <= if_id_instr_d;
      if_id_valid_q  <= if_id_valid_d;
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  // Bubble is unregistered so it reaches ID/EX on the same edge IF/ID holds
  assign id_ex_bubble = stall | branch_taken_ex;

  assign imem_addr    = pc_q;
  assign if_id_pc     = if_id_pc_q;
  assign if_id_instr  = if_id_instr_q;
  assign if_id_valid  = if_id_valid_q;
  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_fetch_stall_ctrl.sv
// Directed bench for fetch_stall_ctrl: a CNT_W=16 instance and a CNT_W=4
// instance driven with identical stimulus; instruction memory is a simple
// address-derived pattern so captured instructions are predictable.
module tb_fetch_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_taken_ex;
  logic [31:0] branch_target_ex;

  logic [31:0] imem_addr, imem_rdata, if_id_pc, if_id_instr;
  logic        if_id_valid, id_ex_bubble;
  logic [15:0] stall_cycles, flush_count;

  logic [31:0] imem_addr4, imem_rdata4, if_id_pc4, if_id_instr4;
  logic        if_id_valid4, id_ex_bubble4;
  logic [3:0]  stall_cycles4, flush_count4;

  int n_vec = 0;
  int n_err = 0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  assign imem_rdata  = mem(imem_addr);
  assign imem_rdata4 = mem(imem_addr4);

  always #5 clk = ~clk;

  fetch_stall_ctrl dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken_ex(branch_taken_ex),
    .branch_target_ex(branch_target_ex), .imem_rdata(imem_rdata),
    .imem_addr(imem_addr), .if_id_pc(if_id_pc), .if_id_instr(if_id_instr),
    .if_id_valid(if_id_valid), .id_ex_bubble(id_ex_bubble),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  fetch_stall_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken_ex(branch_taken_ex),
    .branch_target_ex(branch_target_ex), .imem_rdata(imem_rdata4),
    .imem_addr(imem_addr4), .if_id_pc(if_id_pc4), .if_id_instr(if_id_instr4),
    .if_id_valid(if_id_valid4), .id_ex_bubble(id_ex_bubble4),
    .stall_cycles(stall_cycles4), .flush_count(flush_count4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Full IF/ID + PC check
  task automatic chk_state(input string tag, input logic [31:0] pc,
                           input logic [31:0] ipc, input logic [31:0] ins,
                           input logic v);
    chk({tag, ".pc"},    imem_addr,   pc);
    chk({tag, ".ifpc"},  if_id_pc,    ipc);
    chk({tag, ".instr"}, if_id_instr, ins);
    chk({tag, ".valid"}, 32'(if_id_valid), 32'(v));
  endtask

  // Apply inputs, take one edge, settle
  task automatic step(input logic s, input logic b, input logic [31:0] t);
    stall = s; branch_taken_ex = b; branch_target_ex = t;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    stall = 1'b0; branch_taken_ex = 1'b0; branch_target_ex = '0;
    rst = 1'b1; #2; rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; branch_taken_ex = 1'b0; branch_target_ex = '0;
    #3;
    chk_state("rst", 32'h0, 32'h0, 32'h13, 1'b0);
    chk("rst.stallcnt", 32'(stall_cycles), 32'd0);
    chk("rst.flushcnt", 32'(flush_count), 32'd0);
    chk("rst.bubble", 32'(id_ex_bubble), 32'd0);
    @(posedge clk); #1; rst = 1'b0;

    // Free run
    step(0, 0, 0); chk_state("run1", 32'd4, 32'd0, mem(32'd0), 1'b1);
    step(0, 0, 0); chk_state("run2", 32'd8, 32'd4, mem(32'd4), 1'b1);

    // Single stall at PC=8
    stall = 1'b1; #1; chk("st1.bubble", 32'(id_ex_bubble), 32'd1);
    step(1, 0, 0); chk_state("st1", 32'd8, 32'd4, mem(32'd4), 1'b1);
    chk("st1.cnt", 32'(stall_cycles), 32'd1);
    stall = 1'b0; #1; chk("st1.bubble_off", 32'(id_ex_bubble), 32'd0);
    step(0, 0, 0); chk_state("run3", 32'd12, 32'd8, mem(32'd8), 1'b1);
    step(0, 0, 0); chk_state("run4", 32'd16, 32'd12, mem(32'd12), 1'b1);

    // Stall + flush together from a fresh reset
    @(negedge clk); do_reset();
    chk_state("rst2", 32'h0, 32'h0, 32'h13, 1'b0);
    stall = 1'b1; branch_taken_ex = 1'b1; #1;
    chk("sf.bubble", 32'(id_ex_bubble), 32'd1);
    step(1, 1, 32'h100); chk_state("sf", 32'h100, 32'h0, 32'h13, 1'b0);
    chk("sf.flushcnt", 32'(flush_count), 32'd1);
    chk("sf.stallcnt", 32'(stall_cycles), 32'd0);
    step(0, 0, 0); chk_state("sf.adv", 32'h104, 32'h100, mem(32'h100), 1'b1);

    // Three-cycle stall
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0); chk_state("st3", 32'h104, 32'h100, mem(32'h100), 1'b1);
    end
    chk("st3.cnt", 32'(stall_cycles), 32'd3);
    step(0, 0, 0); chk_state("st3.adv", 32'h108, 32'h104, mem(32'h104), 1'b1);

    // Unaligned target passes through; then wrap-around from FFFF_FFFC
    step(0, 1, 32'h203); chk_state("unal", 32'h203, 32'h104, 32'h13, 1'b0);
    step(0, 1, 32'hFFFF_FFFC); chk("wrap.pc0", imem_addr, 32'hFFFF_FFFC);
    chk("wrap.flushcnt", 32'(flush_count), 32'd3);
    step(0, 0, 0); chk_state("wrap", 32'h0, 32'hFFFF_FFFC, mem(32'hFFFF_FFFC), 1'b1);

    // Saturation: 20 stalls, spurious (IF/ID invalid) stalls still count
    @(negedge clk); do_reset();
    for (int i = 0; i < 20; i++) step(1, 0, 0);
    chk("sat.cnt16", 32'(stall_cycles), 32'd20);
    chk("sat.cnt4", 32'(stall_cycles4), 32'd15);
    chk_state("sat", 32'h0, 32'h0, 32'h13, 1'b0);

    // Reset asserted between edges during a stall
    @(negedge clk); do_reset();
    step(0, 0, 0); step(0, 0, 0);
    step(1, 0, 0); chk("mid.pre", imem_addr, 32'd8);
    #2; rst = 1'b1; #1;
    chk_state("mid", 32'h0, 32'h0, 32'h13, 1'b0);
    chk("mid.stallcnt", 32'(stall_cycles), 32'd0);
    chk("mid.bubble", 32'(id_ex_bubble), 32'd1);
    stall = 1'b0; rst = 1'b0;
    step(0, 0, 0); chk_state("mid.restart", 32'd4, 32'd0, mem(32'd0), 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard timeout
  initial begin
    #20000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
